// File: rtl/ssdec_pkg.sv
// Shared types for the seven-segment capture path: segment pattern type,
// hex glyph table and the capture FSM state encoding.
package ssdec_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h00;

  // Index is the hex value; bit0=a .. bit6=g, 1=lit.
  localparam seg_t SEG_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic [1:0] {IDLE, TRACK, COMMIT, HOLD} ssenc_state_t;

endpackage

// File: rtl/ssenc_lut.sv
// Reverse glyph lookup: segment pattern -> {hit, blank, hex value}.
module ssenc_lut
  import ssdec_pkg::*;
(
  input  seg_t       i_seg,
  output logic       o_hit,
  output logic       o_blank,
  output logic [3:0] o_value
);

  // Glyphs are unique, so at most one entry matches.
  always_comb begin
    o_hit   = 1'b0;
    o_value = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (i_seg == SEG_GLYPH[i]) begin
        o_hit   = 1'b1;
        o_value = 4'(i);
      end
    end
  end

  assign o_blank = (i_seg == SEG_BLANK);

endmodule

// File: rtl/ssenc_capture.sv
// Seven-segment bus receiver: debounces each strobed pattern and commits it as a hex digit.
// Optional saturating error counter port o_err_cnt when SSENC_ERRCNT_EN is defined.
module ssenc_capture
  import ssdec_pkg::*;
#(
  parameter  int NDIGITS       = 4,
  parameter  int STABLE_CYCLES = 3,
  localparam int SELW          = (NDIGITS > 1) ? $clog2(NDIGITS) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [6:0]           i_seg_in,
  input  logic                 i_seg_en,
  input  logic [SELW-1:0]      i_dig_sel,
  output logic [4*NDIGITS-1:0] o_digits_out,
  output logic [NDIGITS-1:0]   o_valid_out,
  output logic                 o_upd,
  output logic [SELW-1:0]      o_upd_idx,
  output logic                 o_err
`ifdef SSENC_ERRCNT_EN
  ,
  output logic [7:0]           o_err_cnt
`endif
);

  localparam int                CNTW    = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNTW-1:0]   CNT_MAX = CNTW'(STABLE_CYCLES - 1);

  typedef struct packed {
    logic            en;
    logic [SELW-1:0] sel;
    seg_t            seg;
  } smp_t;

  smp_t                      r_s;
  logic [CNTW-1:0]           r_cnt;
  ssenc_state_t              r_state;
  logic [NDIGITS-1:0][3:0]   r_digits;
  logic [NDIGITS-1:0]        r_valid;
  logic                      r_upd;
  logic                      r_err;
  logic [SELW-1:0]           r_idx;

  smp_t                      w_s_nxt;
  logic                      w_act_nxt;
  logic                      w_chg;
  logic [CNTW-1:0]           w_cnt_nxt;
  logic                      w_go;
  ssenc_state_t              w_state_nxt;
  logic                      w_hit;
  logic                      w_blank;
  logic [3:0]                w_val;

  // Stability is judged on the sample being registered against the one already held,
  // so the commit lands STABLE_CYCLES edges after the pattern is first captured.
  assign w_s_nxt   = {i_seg_en, i_dig_sel, i_seg_in};
  assign w_act_nxt = w_s_nxt.en && ({1'b0, w_s_nxt.sel} < (SELW+1)'(NDIGITS));
  assign w_chg     = !w_act_nxt || (w_s_nxt != r_s);
  assign w_cnt_nxt = w_chg ? '0 : ((r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1);
  assign w_go      = (w_cnt_nxt == CNT_MAX);

  ssenc_lut u_lut (
    .i_seg   (r_s.seg),
    .o_hit   (w_hit),
    .o_blank (w_blank),
    .o_value (w_val)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_act_nxt) w_state_nxt = w_go ? COMMIT : TRACK;
      TRACK:   if (!w_act_nxt) w_state_nxt = IDLE;
               else if (w_go)  w_state_nxt = COMMIT;
      // A change seen while committing must restart tracking, not park in HOLD.
      COMMIT,
      HOLD:    if (!w_act_nxt) w_state_nxt = IDLE;
               else if (w_chg) w_state_nxt = w_go ? COMMIT : TRACK;
               else            w_state_nxt = HOLD;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s      <= '0;
      r_cnt    <= '0;
      r_digits <= '0;
      r_valid  <= '0;
      r_upd    <= 1'b0;
      r_err    <= 1'b0;
      r_idx    <= '0;
    end else begin
      r_s   <= w_s_nxt;
      r_cnt <= w_cnt_nxt;
      r_upd <= 1'b0;
      r_err <= 1'b0;
      if (r_state == COMMIT) begin
        r_idx <= r_s.sel;
        if (w_hit || w_blank) r_upd <= 1'b1;
        else                  r_err <= 1'b1;
        for (int i = 0; i < NDIGITS; i++) begin
          if (SELW'(i) == r_s.sel) begin
            r_valid[i] <= w_hit;
            if (w_hit) r_digits[i] <= w_val;
          end
        end
      end
    end
  end

`ifdef SSENC_ERRCNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_err_cnt <= 8'h00;
    else if (r_state == COMMIT && !w_hit && !w_blank && r_err_cnt != 8'hFF)
      r_err_cnt <= r_err_cnt + 8'h01;
  end

  assign o_err_cnt = r_err_cnt;
`endif

  assign o_digits_out = r_digits;
  assign o_valid_out  = r_valid;
  assign o_upd        = r_upd;
  assign o_upd_idx    = r_idx;
  assign o_err        = r_err;

endmodule

// File: tb/tb_ssenc_capture.sv
// Directed bench for ssenc_capture (NDIGITS=4, STABLE_CYCLES=3) plus a 5-digit
// instance for the out-of-range digit select case.
module tb_ssenc_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg_in;
  logic        seg_en;
  logic [1:0]  dig_sel;
  logic [15:0] digits;
  logic [3:0]  valid;
  logic        upd, err;
  logic [1:0]  upd_idx;

  logic [6:0]  seg5;
  logic        en5;
  logic [2:0]  sel5;
  logic [19:0] digits5;
  logic [4:0]  valid5;
  logic        upd5, err5;
  logic [2:0]  idx5;

`ifdef SSENC_ERRCNT_EN
  logic [7:0]  err_cnt, err_cnt5;
`endif

  int nvec = 0;
  int nmis = 0;
  int n_upd = 0;
  int n_err = 0;
  logic act5 = 1'b0;

  logic [6:0] glyph [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  always #5 clk = ~clk;

  ssenc_capture #(.NDIGITS(4), .STABLE_CYCLES(3)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_seg_in(seg_in), .i_seg_en(seg_en), .i_dig_sel(dig_sel),
    .o_digits_out(digits), .o_valid_out(valid), .o_upd(upd), .o_upd_idx(upd_idx), .o_err(err)
`ifdef SSENC_ERRCNT_EN
    , .o_err_cnt(err_cnt)
`endif
  );

  ssenc_capture #(.NDIGITS(5), .STABLE_CYCLES(3)) u_dut5 (
    .i_clk(clk), .i_rst(rst), .i_seg_in(seg5), .i_seg_en(en5), .i_dig_sel(sel5),
    .o_digits_out(digits5), .o_valid_out(valid5), .o_upd(upd5), .o_upd_idx(idx5), .o_err(err5)
`ifdef SSENC_ERRCNT_EN
    , .o_err_cnt(err_cnt5)
`endif
  );

  always @(negedge clk) begin
    if (upd) n_upd <= n_upd + 1;
    if (err) n_err <= n_err + 1;
    if (upd5 || err5) act5 <= 1'b1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nmis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int u0, e0;
    rst = 1'b1; seg_en = 1'b1; dig_sel = 2'd2; seg_in = 7'h5B;
    en5 = 1'b0; sel5 = 3'd0; seg5 = 7'h00;

    // Reset with the bus active
    step(2);
    chk("rst_digits", 32'(digits), 32'h0);
    chk("rst_valid",  32'(valid), 32'h0);
    chk("rst_upd",    32'(upd), 32'h0);
    chk("rst_idx",    32'(upd_idx), 32'h0);
    chk("rst_err",    32'(err), 32'h0);
`ifdef SSENC_ERRCNT_EN
    chk("rst_errcnt", 32'(err_cnt), 32'h0);
`endif

    // First commit: capture edge 1, pulse after edge 4
    rst = 1'b0;
    step(3);
    chk("t1_upd_early", 32'(upd), 32'h0);
    step(1);
    chk("t1_upd",    32'(upd), 32'h1);
    chk("t1_idx",    32'(upd_idx), 32'h2);
    chk("t1_digits", 32'(digits), 32'h0200);
    chk("t1_valid",  32'(valid), 32'b0100);
    chk("t1_err",    32'(err), 32'h0);

    // Held pattern yields a single pulse
    u0 = n_upd;
    step(20);
    chk("t2_one_pulse", 32'(n_upd - u0), 32'h1);
    seg_in = 7'h71;
    step(3);
    chk("t2_upd_early", 32'(upd), 32'h0);
    step(1);
    chk("t2_upd",    32'(upd), 32'h1);
    chk("t2_digits", 32'(digits), 32'h0F00);

    // Pattern toggling faster than the stability window
    step(1);
    u0 = n_upd; e0 = n_err;
    dig_sel = 2'd0;
    for (int k = 0; k < 6; k++) begin
      seg_in = k[0] ? 7'h4F : 7'h06;
      step(2);
    end
    chk("t3_no_upd", 32'(n_upd - u0), 32'h0);
    chk("t3_no_err", 32'(n_err - e0), 32'h0);
    chk("t3_digits", 32'(digits), 32'h0F00);
    chk("t3_valid",  32'(valid), 32'b0100);

    // Illegal glyph
    e0 = n_err;
    dig_sel = 2'd1; seg_in = 7'h7E;
    step(3);
    chk("t4_err_early", 32'(err), 32'h0);
    step(1);
    chk("t4_err",    32'(err), 32'h1);
    chk("t4_upd",    32'(upd), 32'h0);
    chk("t4_idx",    32'(upd_idx), 32'h1);
    chk("t4_valid",  32'(valid), 32'b0100);
    chk("t4_digits", 32'(digits), 32'h0F00);
`ifdef SSENC_ERRCNT_EN
    chk("t4_errcnt1", 32'(err_cnt), 32'h1);
`endif
    for (int k = 1; k < 300; k++) begin
      seg_in = k[0] ? 7'h01 : 7'h7E;
      step(4);
    end
    step(1);
    chk("t4_err_pulses", 32'(n_err - e0), 32'd300);
`ifdef SSENC_ERRCNT_EN
    chk("t4_errcnt_sat", 32'(err_cnt), 32'hFF);
`endif

    // Glyph on digit 3, then blank on it
    dig_sel = 2'd3; seg_in = 7'h66;
    step(4);
    chk("t5_upd",    32'(upd), 32'h1);
    chk("t5_digits", 32'(digits), 32'h4F00);
    chk("t5_valid",  32'(valid), 32'b1100);
    seg_in = 7'h00;
    step(4);
    chk("t5_blank_upd",    32'(upd), 32'h1);
    chk("t5_blank_err",    32'(err), 32'h0);
    chk("t5_blank_idx",    32'(upd_idx), 32'h3);
    chk("t5_blank_valid",  32'(valid), 32'b0100);
    chk("t5_blank_digits", 32'(digits), 32'h4F00);

    // Idle bus
    seg_en = 1'b0; seg_in = 7'h3F;
    step(1);
    u0 = n_upd; e0 = n_err;
    step(8);
    chk("t5_idle_upd", 32'(n_upd - u0), 32'h0);
    chk("t5_idle_err", 32'(n_err - e0), 32'h0);

    // Out-of-range digit select on the 5-digit instance
    en5 = 1'b1; sel5 = 3'd5; seg5 = 7'h3F;
    step(8);
    chk("t5_oor_act",   32'(act5), 32'h0);
    chk("t5_oor_valid", 32'(valid5), 32'h0);
    sel5 = 3'd4; seg5 = 7'h4F;
    step(4);
    chk("t5_d4_upd",    32'(upd5), 32'h1);
    chk("t5_d4_idx",    32'(idx5), 32'h4);
    chk("t5_d4_digits", 32'(digits5), 32'h30000);
    chk("t5_d4_valid",  32'(valid5), 32'b10000);

    // Reset in the cycle the counter reaches its last value
    seg_en = 1'b1; dig_sel = 2'd0; seg_in = 7'h6D;
    step(3);
    rst = 1'b1;
    step(1);
    chk("t6_upd",    32'(upd), 32'h0);
    chk("t6_digits", 32'(digits), 32'h0);
    chk("t6_valid",  32'(valid), 32'h0);
`ifdef SSENC_ERRCNT_EN
    chk("t6_errcnt", 32'(err_cnt), 32'h0);
`endif
    rst = 1'b0;
    step(3);
    chk("t6_upd_early", 32'(upd), 32'h0);
    step(1);
    chk("t6_upd2",   32'(upd), 32'h1);
    chk("t6_digits2", 32'(digits), 32'h0005);
    chk("t6_valid2", 32'(valid), 32'b0001);

    // Full glyph sweep on every digit
    for (int d = 0; d < 4; d++) begin
      for (int v = 0; v < 16; v++) begin
        dig_sel = 2'(d); seg_in = glyph[v];
        step(4);
        chk($sformatf("t7_d%0d_v%0d", d, v), 32'((digits >> (4 * d)) & 16'hF), 32'(v));
      end
    end
    chk("t7_valid",  32'(valid), 32'hF);
    chk("t7_digits", 32'(digits), 32'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
